// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a program image into the instruction memory write
// port, checks the trailing checksum word, and holds the CPU while loading.
module instr_mem_loader #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int HOLD_AT_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W:0]   wordCount,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpuHold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic HOLD_BIT = (HOLD_AT_RESET != 0);

  state_t              state_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W:0]     index_reg;
  logic [DATA_W-1:0]   sum_reg;
  logic                loaded_reg;
  logic                handshake;
  logic                last_word;

  // Status outputs are straight decodes of the state register.
  assign inReady   = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign busy      = inReady;
  assign done      = (state_reg == S_DONE);
  assign error     = (state_reg == S_ERROR);
  assign cpuHold   = busy | (HOLD_BIT & ~loaded_reg) | error;

  assign handshake = inValid && inReady;
  assign last_word = (index_reg == (count_reg - 1'b1));

  // Loader FSM: latches the job on start, drives the registered write port
  // during LOAD, and resolves the checksum in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      base_reg     <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      sum_reg      <= '0;
      loaded_reg   <= 1'b0;
      writeAddress <= '0;
      writeData    <= '0;
      writeEnable  <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      writeEnable <= 1'b0;
      unique case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            base_reg  <= baseAddr;
            count_reg <= wordCount;
            index_reg <= '0;
            sum_reg   <= '0;
            state_reg <= (wordCount != '0) ? S_LOAD : S_CHECK;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            // Address addition truncates to ADDR_W, so the image wraps.
            writeAddress <= base_reg + index_reg[ADDR_W-1:0];
            writeData    <= inData;
            writeEnable  <= 1'b1;
            sum_reg      <= sum_reg + inData;
            index_reg    <= index_reg + 1'b1;
            if (last_word) begin
              state_reg <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (handshake) begin
            if (inData == sum_reg) begin
              state_reg  <= S_DONE;
              loaded_reg <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected memory
// writes into a queue, a negedge monitor pops and compares each write.
module tb_instr_mem_loader;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW:0]   wordCount;
  logic          inValid;
  logic [DW-1:0] inData;
  logic          inReady;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;
  logic          writeEnable;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpuHold;

  instr_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .HOLD_AT_RESET(0)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .inValid(inValid), .inData(inData),
    .inReady(inReady), .writeAddress(writeAddress), .writeData(writeData),
    .writeEnable(writeEnable), .busy(busy), .done(done), .error(error),
    .cpuHold(cpuHold)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int write_cnt   = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  logic [DW-1:0]    img[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (writeEnable === 1'b1) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr=0x%05h data=0x%04h, expected no write", writeAddress, writeData);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(writeAddress), 32'(mon_e[AW+DW-1:DW]));
        check("write_data", 32'(writeData), 32'(mon_e[DW-1:0]));
      end
    end
  end

  // Global safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one word until accepted; program words register an expected write.
  task automatic send(input logic [DW-1:0] d, input bit is_prog, input logic [AW-1:0] addr);
    int  tries = 0;
    bit  ok    = 1'b0;
    while (!ok) begin
      inValid = 1'b1;
      inData  = d;
      ok      = inReady;
      if (ok && is_prog) exp_q.push_back({addr, d});
      @(posedge clk);
      #1;
      inValid = 1'b0;
      tries++;
      if (!ok && tries > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: inReady=%0b, expected 1 within 20 cycles", inReady);
        return;
      end
    end
  endtask

  // One complete load of img[] followed by csum; idle < 0 means random gaps.
  task automatic run_load(input logic [AW-1:0] base, input logic [DW-1:0] csum,
                          input int idle, input bit glitch);
    int            count = img.size();
    int            wc0;
    logic [DW-1:0] sum = '0;
    bit            pass;
    for (int i = 0; i < count; i++) sum = sum + img[i];
    pass = (sum == csum);
    $display("load: base=0x%05h count=%0d csum=0x%04h expect_%s", base, count, csum, pass ? "done" : "error");
    start     = 1'b1;
    baseAddr  = base;
    wordCount = (AW+1)'(count);
    @(posedge clk);
    #1;
    start     = 1'b0;
    baseAddr  = AW'($urandom);
    wordCount = (AW+1)'($urandom_range(1, 50));
    check("busy_after_start", 32'(busy), 32'(1));
    wc0 = write_cnt;
    for (int i = 0; i < count; i++) begin
      int gaps = (idle < 0) ? $urandom_range(0, 2) : idle;
      repeat (gaps) begin
        @(posedge clk);
        #1;
      end
      if (glitch && i == 1) begin
        start    = 1'b1;
        baseAddr = ~base;
      end
      send(img[i], 1'b1, AW'(base + AW'(i)));
      start = 1'b0;
    end
    send(csum, 1'b0, '0);
    check("done",          32'(done),    32'(pass));
    check("error",         32'(error),   32'(!pass));
    check("cpuHold",       32'(cpuHold), 32'(!pass));
    check("busy_end",      32'(busy),    32'(0));
    check("write_count",   32'(write_cnt - wc0), 32'(count));
  endtask

  initial begin
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    rst = 1'b1; start = 1'b0; baseAddr = '0; wordCount = '0;
    inValid = 1'b0; inData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inReady",  32'(inReady),      0);
    check("rst_we",       32'(writeEnable),  0);
    check("rst_busy",     32'(busy),         0);
    check("rst_done",     32'(done),         0);
    check("rst_error",    32'(error),        0);
    check("rst_cpuHold",  32'(cpuHold),      0);
    check("rst_waddr",    32'(writeAddress), 0);
    check("rst_wdata",    32'(writeData),    0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 and T2: good image, bad checksum, then recovery.
    img = '{16'h1111, 16'h2222, 16'h3333};
    run_load(20'h00010, 16'h6666, 0, 1'b0);
    run_load(20'h00010, 16'h6667, 0, 1'b0);
    run_load(20'h00010, 16'h6666, 0, 1'b0);
    // T3: address wrap at the top of memory.
    img = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    run_load(20'hFFFFE, 16'hA001 + 16'hB002 + 16'hC003 + 16'hD004, 0, 1'b0);
    // T4: one idle cycle before every word.
    img = '{16'h0F0F, 16'hF0F0, 16'h1234, 16'h4321};
    run_load(20'h00400, 16'h0F0F + 16'hF0F0 + 16'h1234 + 16'h4321, 1, 1'b0);
    // T5: empty image, then a start pulse during LOAD.
    img.delete();
    run_load(20'h00123, 16'h0000, 0, 1'b0);
    img = '{16'h0001, 16'h0002, 16'h0003};
    run_load(20'h00200, 16'h0006, 0, 1'b1);

    // Randomized loads with random gaps and occasional bad checksums.
    for (int n = 0; n < 12; n++) begin
      img.delete();
      s = '0;
      for (int i = 0; i < $urandom_range(1, 12); i++) begin
        img.push_back(DW'($urandom));
        s = s + img[$];
      end
      b = (n % 3 == 0) ? AW'(20'hFFFFF - $urandom_range(0, 6)) : AW'($urandom);
      if ($urandom_range(0, 3) == 0) s = s ^ DW'($urandom_range(1, 16'hFFFF));
      run_load(b, s, -1, 1'b0);
    end

    // Reset after 2 of 5 words: partial writes stand, loader returns to IDLE.
    $display("load: base=0x00500 count=5 reset after 2 words");
    start = 1'b1; baseAddr = 20'h00500; wordCount = 21'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    send(16'hCAFE, 1'b1, 20'h00500);
    send(16'hBEEF, 1'b1, 20'h00501);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_we",      32'(writeEnable), 0);
    check("midrst_inReady", 32'(inReady),     0);
    check("midrst_busy",    32'(busy),        0);
    check("midrst_cpuHold", 32'(cpuHold),     0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
